// File: rtl/hazard_ctrl_seq.sv
// Hazard control for the 5-stage pipeline: load-use stalls (with multi-cycle
// load latency), ID-stage branch-compare hazards, MEM-to-ID branch operand
// forwarding, taken-branch squash and a saturating stall-cycle counter.
module hazard_ctrl_seq #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_IN_ID = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [AW-1:0]    ex_dst,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [AW-1:0]    mem_dst,
  input  logic             br_taken,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             id_flush,
  output logic             if_flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  // The IDLE cycle that detects the hazard is the first stall cycle, so
  // LD_WAIT only has to cover the remaining LOAD_LAT-1 cycles.
  localparam logic [3:0]       REM_INIT  = 4'(LOAD_LAT - 1);
  localparam logic             MULTI_LAT = (LOAD_LAT > 1);
  localparam logic             BR_EN     = (BR_IN_ID != 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;

  logic ex_rs_hit, ex_rt_hit, ex_hit;
  logic mem_rs_hit, mem_rt_hit, mem_hit;
  logic load_use, br_ex_haz, br_mem_ld_haz, br_mem_fwd;

  logic stall_raw, id_flush_raw, fwd_a_raw, fwd_b_raw;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic          use_r,
                                     input logic [AW-1:0] r,
                                     input logic [AW-1:0] dst);
    return use_r && (r != '0) && (r == dst);
  endfunction

  assign ex_rs_hit  = reg_match(id_use_rs, id_rs, ex_dst);
  assign ex_rt_hit  = reg_match(id_use_rt, id_rt, ex_dst);
  assign ex_hit     = ex_rs_hit | ex_rt_hit;
  assign mem_rs_hit = reg_match(id_use_rs, id_rs, mem_dst);
  assign mem_rt_hit = reg_match(id_use_rt, id_rt, mem_dst);
  assign mem_hit    = mem_rs_hit | mem_rt_hit;

  assign load_use      = ex_memread & ex_hit;
  assign br_ex_haz     = BR_EN & id_branch & ex_regwrite & ex_hit;
  assign br_mem_ld_haz = BR_EN & id_branch & mem_memread & mem_regwrite & mem_hit;
  assign br_mem_fwd    = BR_EN & id_branch & mem_regwrite & mem_hit;

  // State and remaining-stall register; reset aborts any load wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state: enter LD_WAIT on a multi-cycle load-use, leave when rem hits 1.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (load_use && MULTI_LAT) begin
          state_d = LD_WAIT;
          rem_d   = REM_INIT;
        end
      end
      LD_WAIT: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Outputs: prioritised hazard decode in IDLE, unconditional bubble in LD_WAIT.
  always_comb begin
    stall_raw    = 1'b0;
    id_flush_raw = 1'b0;
    fwd_a_raw    = 1'b0;
    fwd_b_raw    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use || br_ex_haz || br_mem_ld_haz) begin
          stall_raw    = 1'b1;
          id_flush_raw = 1'b1;
        end else if (br_mem_fwd) begin
          fwd_a_raw = mem_rs_hit;
          fwd_b_raw = mem_rt_hit;
        end
      end
      LD_WAIT: begin
        stall_raw    = 1'b1;
        id_flush_raw = 1'b1;
      end
      default: begin
        stall_raw    = 1'b0;
        id_flush_raw = 1'b0;
      end
    endcase
  end

  // Combinational outputs are forced low for as long as reset is asserted.
  assign stall    = rst_n & stall_raw;
  assign id_flush = rst_n & id_flush_raw;
  assign fwd_a    = rst_n & fwd_a_raw;
  assign fwd_b    = rst_n & fwd_b_raw;
  assign if_flush = rst_n & br_taken & ~stall_raw;
  assign busy     = (state_q == LD_WAIT);

  // Stall-cycle counter: clear wins, otherwise count stalls up to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_raw && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
